// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the zero-latency ROM and fills IF/ID.
// Optional JAL predecode redirect is built when FETCH_JAL_PREDECODE_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT  = 32'h0000_004C,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        ifid_predicted,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {RUN, PARK} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        mis_q, mis_d;
  logic [31:0] cnt_q, cnt_d;

`ifdef FETCH_JAL_PREDECODE_EN
  logic        pred_q, pred_d;
  logic        jal_hit;
  logic [31:0] jal_tgt;

  assign jal_hit = (imem_data[6:0] == 7'b1101111);
  assign jal_tgt = pc_q + {{11{imem_data[31]}}, imem_data[31], imem_data[19:12],
                           imem_data[20], imem_data[30:21], 1'b0};
`endif

  assign imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    mis_d        = mis_q;
    cnt_d        = cnt_q;
`ifdef FETCH_JAL_PREDECODE_EN
    pred_d       = pred_q;
`endif
    if (redirect) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      ifid_pc_d    = pc_q;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
`ifdef FETCH_JAL_PREDECODE_EN
      pred_d       = 1'b0;
`endif
      if (redirect_pc[1:0] != 2'b00) mis_d = 1'b1;
    end else if (!stall) begin
      ifid_pc_d = pc_q;
      unique case (state_q)
        RUN: begin
          ifid_instr_d = imem_data;
          ifid_valid_d = 1'b1;
          cnt_d        = cnt_q + 32'd1;
          pc_d         = pc_q + 32'd4;
`ifdef FETCH_JAL_PREDECODE_EN
          pred_d       = 1'b0;
          if (jal_hit) begin
            // Decode sees predicted=1 and must not redirect for this JAL again.
            pc_d   = {jal_tgt[31:2], 2'b00};
            pred_d = 1'b1;
            if (jal_tgt[1:0] != 2'b00) mis_d = 1'b1;
          end
`endif
        end
        PARK: begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
`ifdef FETCH_JAL_PREDECODE_EN
          pred_d       = 1'b0;
`endif
        end
        default: ;
      endcase
    end
    // The state always tracks whether the next PC lies in the populated ROM.
    state_d = (pc_d >= PC_LIMIT) ? PARK : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= (RESET_PC >= PC_LIMIT) ? PARK : RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      mis_q        <= 1'b0;
      cnt_q        <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      mis_q        <= mis_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef FETCH_JAL_PREDECODE_EN
  always_ff @(posedge clk) begin
    if (rst) pred_q <= 1'b0;
    else     pred_q <= pred_d;
  end
  assign ifid_predicted = pred_q;
`else
  assign ifid_predicted = 1'b0;
`endif

  assign ifid_pc      = ifid_pc_q;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_valid   = ifid_valid_q;
  assign misalign_err = mis_q;
  assign fetch_cnt    = cnt_q;

endmodule
